// File: rtl/dftprobe_bank_if.sv
// Scan/strobe bundle for dftprobe_bank: the test controller drives it as
// master and the probe bank responds as slave.
interface dftprobe_bank_if #(
   parameter int PW = 8
);
   logic          se;
   logic          si;
   logic          so;
   logic          cap;
   logic          upd;
   logic          pmode;
   logic [PW-1:0] plen;
   logic          rel;
   logic          busy;
   logic          done;

   modport master (
      output se, si, cap, upd, pmode, plen, rel,
      input  so, busy, done
   );

   modport slave (
      input  se, si, cap, upd, pmode, plen, rel,
      output so, busy, done
   );
endinterface

// File: rtl/dftprobe_bank.sv
// Multi-channel DFT probe bank: passes functional signals through or substitutes
// scanned-in values, statically or for a programmed number of cycles.
module dftprobe_bank #(
   parameter int N  = 8,
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          CELG,
   input  logic          CELSUB,
   input  logic          CELV,
   input  logic          ten,
   input  logic [N-1:0]  i,
   output logic [N-1:0]  o,
   dftprobe_bank_if.slave pif
);
   typedef enum logic [1:0] {OFF, STATIC, PULSE} state_t;

   localparam logic [PW-1:0] PC_ONE = PW'(1);

   state_t        state_q, state_d;
   logic [N-1:0]  sr_q, sr_d;
   logic [N-1:0]  fr_q, fr_d;
   logic [N-1:0]  cm_q, cm_d;
   logic [PW-1:0] pc_q, pc_d;
   logic          done_q, done_d;

   logic unused_power;
   assign unused_power = CELG ^ CELSUB ^ CELV;

   // One event per cycle in priority rel > upd > cap > se; the pulse countdown
   // only runs when neither rel nor upd claims the cycle.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      fr_d    = fr_q;
      cm_d    = cm_q;
      pc_d    = pc_q;
      done_d  = 1'b0;
      if (!ten) begin
         state_d = OFF;
         pc_d    = '0;
      end else if (pif.rel) begin
         state_d = OFF;
         pc_d    = '0;
      end else if (pif.upd) begin
         fr_d = sr_q;
         cm_d = sr_q;
         if (pif.pmode) begin
            state_d = PULSE;
            pc_d    = (pif.plen == '0) ? PC_ONE : pif.plen;
         end else begin
            state_d = STATIC;
            pc_d    = '0;
         end
      end else begin
         if (state_q == PULSE) begin
            if (pc_q == PC_ONE) begin
               state_d = OFF;
               pc_d    = '0;
               done_d  = 1'b1;
            end else begin
               pc_d = pc_q - PC_ONE;
            end
         end
         if (pif.cap) begin
            sr_d = i;
         end else if (pif.se) begin
            sr_d        = sr_q >> 1;
            sr_d[N-1]   = pif.si;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= OFF;
         sr_q    <= '0;
         fr_q    <= '0;
         cm_q    <= '0;
         pc_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         fr_q    <= fr_d;
         cm_q    <= cm_d;
         pc_q    <= pc_d;
         done_q  <= done_d;
      end
   end

   assign o        = (ten && state_q != OFF) ? ((cm_q & fr_q) | (~cm_q & i)) : i;
   assign pif.so   = sr_q[0];
   assign pif.busy = (state_q == PULSE);
   assign pif.done = done_q;
endmodule

// File: doc/dftprobe_bank.md
# dftprobe_bank

Parametrised multi-channel DFT test-data-input probe bank for the stepdown loop control. Between N functional signals and their consumers, it passes each signal through transparently or substitutes a value loaded over a serial scan path. The substitution can be static (held until released) or pulsed (auto-released after a programmed number of cycles). It also captures live channel values for serial readout. It replaces per-signal single-channel tdi probes with one scannable, maskable bank.

## Interface
- N, 8, channel count, 1..32
- PW, 8, pulse-length counter width, 2..16
- clk  in  1  probe clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- CELG  in  1  cell ground; no functional effect
- CELSUB  in  1  substrate; no functional effect
- CELV  in  1  cell supply; no functional effect
- ten  in  1  global test enable; 0 forces full transparency
- i  in  N  functional inputs
- o  out  N  probe outputs, tdi_* nets
- se  in  1  shift enable
- si  in  1  scan data in
- so  out  1  scan data out, = sr[0]
- cap  in  1  capture strobe, sr <= i
- upd  in  1  update strobe, fr <= sr, start forcing
- pmode  in  1  at upd: 0 static force, 1 pulsed force
- plen  in  PW  pulse length in cycles, sampled at upd
- rel  in  1  release strobe, end any force
- busy  out  1  1 while in PULSE
- done  out  1  one-cycle pulse when a PULSE expires naturally

## Operation
- Registers:
  - sr[N-1:0] shift/capture register
  - fr[N-1:0] force values
  - cm[N-1:0] channel mask
  - pc[PW-1:0] pulse counter
  - state in {OFF, STATIC, PULSE}
- Output mux, combinational:
  - o[k] = (ten & state!=OFF & cm[k]) ? fr[k] : i[k]
- Per-cycle priority when ten=1: rel > upd > cap > se.
  - rel: state->OFF; fr and cm are kept.
  - upd:
    - fr<=sr; cm<=sr (the mask is the same scanned word, so unforced channels shift in 0).
    - pmode=0: state->STATIC.
    - pmode=1: state->PULSE, pc<=max(plen,1).
  - cap: sr<=i (raw inputs, not o).
  - se: sr<={si, sr[N-1:1]}; so shows the new sr[0] next cycle.
- PULSE:
  - pc decrements each cycle no higher-priority event occurs.
  - In the cycle pc==1: next state OFF, done=1 for exactly that following cycle.
- upd while in STATIC or PULSE retargets immediately and reloads pc; done is not asserted for the aborted pulse.
- cap/se while forcing are allowed; shifting does not disturb fr or o.
- ten=0:
  - o=i immediately (combinational).
  - At the next edge: state->OFF, pc->0, sr held.
  - All strobes are ignored and done is not asserted.
- Power pins are carried for netlist compatibility only.

## Timing
- Reset values: sr=0, fr=0, cm=0, pc=0, state=OFF, so=0, busy=0, done=0. o=i during and after reset.
- rst mid-PULSE or mid-STATIC: release at that edge, no done.
- Force latency: upd at edge t; o shows fr from t+1 (registered state/fr, combinational mux).
- PULSE of plen=L forces o for exactly L cycles. busy=1 for those L cycles. done is high in cycle L+1, coincident with o returning to i.
- plen=0 behaves as plen=1.
- Scan: N se cycles load a full word. The first bit shifted in lands in sr[0] after N shifts.
- so is registered: valid 1 cycle after each shift or capture.
- Simultaneous upd+rel: rel wins, no force starts.
- Simultaneous cap+se: capture only.

## Test plan
- Reset/transparency: rst=1 then 0, ten=1, i=8'hA5, no strobes -> o=8'hA5, so=0, busy=0, done=0.
- Static force: shift in 8'h3C (8 se cycles), upd with pmode=0, i=8'hFF -> from the next cycle o=8'hFF with channels 2..5 driven to 1 (fr=cm=3C gives o=FF). Repeat with i=8'h00 -> o=8'h3C. rel -> o=i the following cycle.
- Pulse: word 8'h0F, upd with pmode=1, plen=3, i=8'h00 -> o=8'h0F for exactly 3 cycles, busy=1 for those 3, done=1 in the 4th cycle with o=8'h00.
- Retarget/abort: during PULSE (plen=5), upd at count 2 with a new word 8'hF0, pmode=0 -> o switches to 8'hF0 next cycle, no done. Drop ten -> o=i in the same cycle, state OFF next edge.
- Capture/readout: i=8'b1000_0001, cap, then 8 se cycles with si=0 -> so sequence 1,0,0,0,0,0,0,1 (LSB first).
- Priority/boundary: upd+rel together -> no force. plen=0 -> single-cycle force with done. rst asserted mid-PULSE -> o=i next cycle, no done.
